slice_loader: RTL and testbench
===============================

SLICE_LOADER -- requirements
Module: slice_loader

Interface
REQ-001 SHALL have parameter SLICE, default 25, meaning bits per slice, equal to the datapath line width.
REQ-002 SHALL have parameter NSLICE, default 64, meaning slices per frame.
REQ-003 SHALL have parameter CW, default 6, meaning sliceCount width; NSLICE <= 2^CW is required.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous active-low reset; rst=0 sampled at a clk edge resets the block.
REQ-006 SHALL have port bitIn, input, 1 bit: serial slice data, LSB first.
REQ-007 SHALL have port bitValid, input, 1 bit: bitIn is valid this cycle.
REQ-008 SHALL have port bitReady, output, 1 bit: the block accepts bitIn this cycle.
REQ-009 SHALL have port done, input, 1 bit: completion level from the downstream datapath.
REQ-010 SHALL have port line, output, SLICE bits: slice presented to the datapath memory.
REQ-011 SHALL have port initLine, output, 1 bit: one-cycle load strobe for the datapath memory.
REQ-012 SHALL have port start, output, 1 bit: one-cycle start strobe for the datapath controller.
REQ-013 SHALL have port busy, output, 1 bit: a slice is in flight downstream.
REQ-014 SHALL have port sliceCount, output, CW bits: number of completed slices in the current frame.
REQ-015 SHALL have port frameDone, output, 1 bit: one-cycle pulse when slice NSLICE-1 completes.

Function
REQ-016 SHALL hold a fill register (SLICE bits), a fill bit counter (0..SLICE-1), a fillFull flag and a line register driving line.
REQ-017 SHALL drive bitReady = ~fillFull, combinationally.
REQ-018 SHALL count a bit as accepted when bitValid & bitReady; the accepted bit SHALL be written to fill[cnt], then cnt increments.
REQ-019 SHALL, on acceptance of the bit with cnt=SLICE-1, wrap cnt to 0 and set fillFull at the same edge.
REQ-020 SHALL leave fill, cnt and fillFull unchanged while bitValid=0.
REQ-021 SHALL implement FSM states IDLE, LOAD, START, WAIT, and SHALL drive no output that depends combinationally on done.
REQ-022 IDLE -> LOAD when fillFull=1; on that edge line <= fill and fillFull <= 0.
REQ-023 LOAD -> START unconditionally; initLine=1 only in LOAD.
REQ-024 START -> WAIT unconditionally; start=1 only in START.
REQ-025 SHALL register done every cycle as doneQ, and SHALL define completion as WAIT & done & ~doneQ (a rising edge of done); a done level already high on entry to WAIT SHALL NOT complete the slice.
REQ-026 On completion with fillFull=1, WAIT -> LOAD, with the line copy and fillFull clear on the same edge.
REQ-027 On completion with fillFull=0, WAIT -> IDLE.
REQ-028 SHALL drive busy=1 in LOAD, START and WAIT, and busy=0 in IDLE.
REQ-029 On completion, sliceCount SHALL increment; if it was NSLICE-1 it SHALL wrap to 0 and frameDone SHALL pulse high for exactly the following cycle.
REQ-030 line SHALL change only on an IDLE->LOAD or WAIT->LOAD edge and SHALL be stable from LOAD through WAIT.
REQ-031 SHALL continue filling the next slice during LOAD, START and WAIT (double buffering).
REQ-032 Latency from the last bit accepted (edge E, in IDLE) SHALL be: LOAD at E+1 (initLine), START at E+2, WAIT at E+3.
REQ-033 A fill completing on the same edge as a completion SHALL set fillFull at that edge, with WAIT -> IDLE; the slice is issued via IDLE -> LOAD one cycle later.

Reset
REQ-034 On rst=0: state=IDLE, fill=0, cnt=0, fillFull=0, line=0, doneQ=0, sliceCount=0.
REQ-035 Immediately after reset: initLine=0, start=0, busy=0, frameDone=0, bitReady=1.
REQ-036 Reset asserted mid-fill or mid-WAIT SHALL discard partial bits and the in-flight slice, with no strobe issued.

Verification
REQ-037 Reset, then 25 accepted bits with pattern 0x1ABCDEF (LSB first) -> initLine high 1 cycle after the 25th bit, line=25'h1ABCDEF, start high the next cycle, busy=1.
REQ-038 Hold done=1 throughout WAIT entry, then drop it and raise it again -> exactly one completion, sliceCount=1, state returns to IDLE.
REQ-039 Stream 50 bits back-to-back with done withheld -> bitReady=0 after bit 50; on done rising, immediate LOAD with line = second slice and bitReady=1 on the next cycle.
REQ-040 Run 64 slices with NSLICE=64 -> frameDone pulses exactly once, 1 cycle after the 64th completion, and sliceCount reads 0 afterwards.
REQ-041 Apply rst=0 after 12 bits of a slice -> cnt=0; a fresh 25 bits then yields line equal to the new pattern only.
REQ-042 Make the 25th bit acceptance coincide with a done rising edge while fillFull=0 -> WAIT -> IDLE, then LOAD one cycle later with the new slice.

Source files
------------

// File: rtl/slice_loader.sv
// slice_loader: assembles a serial LSB-first bit stream into SLICE-wide
// slices and hands each one to a downstream datapath through a
// load/start/wait handshake. The next slice fills while the current one
// is in flight, so there are two buffers: fill_r collects bits and line_r
// holds the issued slice.
module slice_loader #(
  parameter int SLICE  = 25,
  parameter int NSLICE = 64,
  parameter int CW     = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bitIn,
  input  logic             bitValid,
  output logic             bitReady,
  input  logic             done,
  output logic [SLICE-1:0] line,
  output logic             initLine,
  output logic             start,
  output logic             busy,
  output logic [CW-1:0]    sliceCount,
  output logic             frameDone
);

  localparam int BW = (SLICE > 1) ? $clog2(SLICE) : 1;
  localparam logic [BW-1:0] CNT_LAST   = BW'(SLICE - 1);
  localparam logic [BW-1:0] CNT_ONE    = BW'(1);
  localparam logic [BW-1:0] CNT_ZERO   = BW'(0);
  localparam logic [CW-1:0] SLICE_LAST = CW'(NSLICE - 1);
  localparam logic [CW-1:0] SC_ONE     = CW'(1);
  localparam logic [CW-1:0] SC_ZERO    = CW'(0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    START = 2'd2,
    WAIT  = 2'd3
  } state_t;

  state_t           state_r;
  state_t           stateNext_s;
  logic [SLICE-1:0] fill_r;
  logic [BW-1:0]    cnt_r;
  logic             fillFull_r;
  logic [SLICE-1:0] line_r;
  logic             doneQ_r;
  logic [CW-1:0]    sliceCount_r;
  logic             frameDone_r;
  logic             initLine_r;
  logic             start_r;
  logic             busy_r;
  logic             accept_s;
  logic             loadLine_s;
  logic             complete_s;

  // A bit is taken whenever the fill buffer still has room.
  assign accept_s = bitValid & ~fillFull_r;

  assign bitReady   = ~fillFull_r;
  assign line       = line_r;
  assign initLine   = initLine_r;
  assign start      = start_r;
  assign busy       = busy_r;
  assign sliceCount = sliceCount_r;
  assign frameDone  = frameDone_r;

  // Next-state decode; completion is a rising edge of done seen in WAIT.
  always_comb begin
    stateNext_s = state_r;
    loadLine_s  = 1'b0;
    complete_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (fillFull_r) begin
          stateNext_s = LOAD;
          loadLine_s  = 1'b1;
        end else begin
          stateNext_s = IDLE;
        end
      end
      LOAD:  stateNext_s = START;
      START: stateNext_s = WAIT;
      WAIT: begin
        if (done && !doneQ_r) begin
          complete_s = 1'b1;
          if (fillFull_r) begin
            stateNext_s = LOAD;
            loadLine_s  = 1'b1;
          end else begin
            stateNext_s = IDLE;
          end
        end else begin
          stateNext_s = WAIT;
        end
      end
      default: stateNext_s = IDLE;
    endcase
  end

  // State register plus done history used for edge detection.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
      doneQ_r <= 1'b0;
    end else begin
      state_r <= stateNext_s;
      doneQ_r <= done;
    end
  end

  // Fill buffer: shift-in by index, flag full on the last bit, release on load.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fill_r     <= '0;
      cnt_r      <= CNT_ZERO;
      fillFull_r <= 1'b0;
    end else begin
      if (accept_s) begin
        fill_r[cnt_r] <= bitIn;
        if (cnt_r == CNT_LAST) begin
          cnt_r      <= CNT_ZERO;
          fillFull_r <= 1'b1;
        end else begin
          cnt_r <= cnt_r + CNT_ONE;
        end
      end else if (loadLine_s) begin
        fillFull_r <= 1'b0;
      end
    end
  end

  // Issued slice: copied from the fill buffer only on entry to LOAD.
  always_ff @(posedge clk) begin
    if (!rst) begin
      line_r <= '0;
    end else if (loadLine_s) begin
      line_r <= fill_r;
    end
  end

  // Completed-slice counter with a one-cycle end-of-frame pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sliceCount_r <= SC_ZERO;
      frameDone_r  <= 1'b0;
    end else if (complete_s) begin
      if (sliceCount_r == SLICE_LAST) begin
        sliceCount_r <= SC_ZERO;
        frameDone_r  <= 1'b1;
      end else begin
        sliceCount_r <= sliceCount_r + SC_ONE;
        frameDone_r  <= 1'b0;
      end
    end else begin
      frameDone_r <= 1'b0;
    end
  end

  // Strobes decoded from the next state so they are glitch-free flops.
  always_ff @(posedge clk) begin
    if (!rst) begin
      initLine_r <= 1'b0;
      start_r    <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      initLine_r <= (stateNext_s == LOAD);
      start_r    <= (stateNext_s == START);
      busy_r     <= (stateNext_s != IDLE);
    end
  end

endmodule

// File: tb/tb_slice_loader.sv
// tb_slice_loader: directed, table-driven bench for slice_loader with the
// default geometry (25-bit slices, 64 slices per frame).
module tb_slice_loader;

  logic        clk;
  logic        rst;
  logic        bitIn;
  logic        bitValid;
  logic        bitReady;
  logic        done;
  logic [24:0] line;
  logic        initLine;
  logic        start;
  logic        busy;
  logic [5:0]  sliceCount;
  logic        frameDone;

  int nCompared   = 0;
  int nMismatched = 0;
  int fdCount     = 0;

  slice_loader #(.SLICE(25), .NSLICE(64), .CW(6)) dut (
    .clk(clk), .rst(rst), .bitIn(bitIn), .bitValid(bitValid),
    .bitReady(bitReady), .done(done), .line(line), .initLine(initLine),
    .start(start), .busy(busy), .sliceCount(sliceCount), .frameDone(frameDone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every frameDone pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (frameDone === 1'b1) fdCount++;
  end

  typedef struct {
    logic [24:0] pattern;
    logic        holdDone;
    logic [24:0] expLine;
    logic [5:0]  expCount;
  } vec_t;

  vec_t vecs[4];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Present n bits of pat (LSB first), holding each one until accepted.
  task automatic sendBits(input logic [24:0] pat, input int n);
    int idx;
    int guard;
    logic wasReady;
    idx = 0;
    guard = 0;
    while (idx < n && guard < 200) begin
      bitValid = 1'b1;
      bitIn    = pat[idx];
      wasReady = bitReady;
      step();
      if (wasReady) idx++;
      guard++;
    end
    bitValid = 1'b0;
    bitIn    = 1'b0;
    if (idx < n) begin
      nCompared++;
      nMismatched++;
      $display("FAIL send_timeout: got %0d bits, want %0d", idx, n);
    end
  endtask

  logic [24:0] patA, patB, patC, patD, patE;

  initial begin
    vecs[0] = '{pattern: 25'h1ABCDEF, holdDone: 1'b1, expLine: 25'h1ABCDEF, expCount: 6'd1};
    vecs[1] = '{pattern: 25'h0000001, holdDone: 1'b0, expLine: 25'h0000001, expCount: 6'd2};
    vecs[2] = '{pattern: 25'h1FFFFFF, holdDone: 1'b1, expLine: 25'h1FFFFFF, expCount: 6'd3};
    vecs[3] = '{pattern: 25'h0A5A5A5, holdDone: 1'b0, expLine: 25'h0A5A5A5, expCount: 6'd4};
    patA = 25'h0123456;
    patB = 25'h1555AAA;
    patC = 25'h0F0F0F0;
    patD = 25'h1C3A5E7;
    patE = 25'h1234567;

    rst = 1'b0; bitValid = 1'b0; bitIn = 1'b0; done = 1'b0;
    step(); step();
    rst = 1'b1;
    check("rst_bitReady", bitReady, 1);
    check("rst_initLine", initLine, 0);
    check("rst_start", start, 0);
    check("rst_busy", busy, 0);
    check("rst_frameDone", frameDone, 0);
    check("rst_line", line, 0);
    check("rst_sliceCount", sliceCount, 0);

    // Table: fill, load/start/wait latency, completion with and without a held done.
    for (int v = 0; v < 4; v++) begin
      done = 1'b0;
      sendBits(vecs[v].pattern, 25);
      check("tbl_full_ready", bitReady, 0);
      check("tbl_no_early_init", initLine, 0);
      if (vecs[v].holdDone) done = 1'b1;
      step();
      check("tbl_initLine", initLine, 1);
      check("tbl_line", line, vecs[v].expLine);
      check("tbl_busy_load", busy, 1);
      check("tbl_ready_after_load", bitReady, 1);
      step();
      check("tbl_start", start, 1);
      check("tbl_init_one_cycle", initLine, 0);
      step();
      check("tbl_start_one_cycle", start, 0);
      check("tbl_busy_wait", busy, 1);
      if (vecs[v].holdDone) begin
        step(); step(); step();
        check("tbl_held_done_busy", busy, 1);
        check("tbl_held_done_count", sliceCount, vecs[v].expCount - 6'd1);
        done = 1'b0;
        step();
      end
      done = 1'b1;
      step();
      check("tbl_complete_busy", busy, 0);
      check("tbl_complete_count", sliceCount, vecs[v].expCount);
      check("tbl_frameDone", frameDone, 0);
      done = 1'b0;
      step();
      check("tbl_single_complete", sliceCount, vecs[v].expCount);
      check("tbl_idle_busy", busy, 0);
    end

    // Back-to-back 50 bits with done withheld: double buffer fills and stalls.
    done = 1'b0;
    sendBits(patA, 25);
    sendBits(patB, 25);
    check("b2b_ready_low", bitReady, 0);
    check("b2b_line_first", line, patA);
    check("b2b_busy", busy, 1);
    check("b2b_count", sliceCount, 4);
    done = 1'b1;
    step();
    check("b2b_reload_init", initLine, 1);
    check("b2b_line_second", line, patB);
    check("b2b_ready_again", bitReady, 1);
    check("b2b_count_after", sliceCount, 5);
    done = 1'b0;
    step();
    check("b2b_start", start, 1);
    step();
    done = 1'b1;
    step();
    check("b2b_second_complete", sliceCount, 6);
    check("b2b_idle", busy, 0);
    done = 1'b0;
    step();

    // Fill completing on the same edge as a completion with fillFull=0.
    sendBits(patC, 25);
    step(); step(); step();
    sendBits(patD, 24);
    bitValid = 1'b1; bitIn = patD[24]; done = 1'b1;
    step();
    bitValid = 1'b0; bitIn = 1'b0;
    check("coin_idle", busy, 0);
    check("coin_no_init", initLine, 0);
    check("coin_full", bitReady, 0);
    check("coin_count", sliceCount, 7);
    check("coin_line_old", line, patC);
    done = 1'b0;
    step();
    check("coin_load", initLine, 1);
    check("coin_line_new", line, patD);
    check("coin_busy", busy, 1);
    step(); step();
    done = 1'b1;
    step();
    check("coin_second_count", sliceCount, 8);
    done = 1'b0;
    step();

    // Reset mid-fill discards partial bits; reset mid-WAIT drops the slice.
    sendBits(25'h1FFFFFF, 12);
    rst = 1'b0;
    step();
    rst = 1'b1;
    check("midfill_rst_count", sliceCount, 0);
    check("midfill_rst_line", line, 0);
    check("midfill_rst_ready", bitReady, 1);
    sendBits(patE, 25);
    check("fresh_full", bitReady, 0);
    step();
    check("fresh_init", initLine, 1);
    check("fresh_line", line, patE);
    step(); step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    check("midwait_rst_busy", busy, 0);
    check("midwait_rst_start", start, 0);
    check("midwait_rst_line", line, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("midwait_no_strobe", {30'd0, initLine, start}, 0);
    end

    // Full frame of 64 slices: one frameDone pulse after the last completion.
    fdCount = 0;
    for (int s = 0; s < 64; s++) begin
      sendBits(25'(s * 37 + 1), 25);
      step(); step(); step();
      done = 1'b1;
      step();
      if (s == 62) begin
        check("frame_count_63", sliceCount, 63);
        check("frame_no_early_pulse", frameDone, 0);
      end
      if (s == 63) begin
        check("frame_pulse", frameDone, 1);
        check("frame_wrap", sliceCount, 0);
      end
      done = 1'b0;
      step();
    end
    check("frame_pulse_count", fdCount, 1);
    check("frame_pulse_end", frameDone, 0);
    check("frame_count_after", sliceCount, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
